fetch_sequencer: RTL and testbench

- Instruction-fetch controller sitting between the program counter logic and the combinational-read instruction memory.
- Owns the fetch PC and drives the memory read address.
- Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects with flush, end-of-program detection (out-of-range address or all-zero word) and misaligned-target faults.

---
 rtl/fetch_sequencer_if.sv | 47 ++++
 rtl/fetch_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer bus: imem read port, redirect/stall controls, decode handshake
interface fetch_sequencer_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        done;
    logic        fault;
    logic [31:0] fault_pc;

    // sequencer side
    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        input  stall,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output done,
        output fault,
        output fault_pc
    );

    // memory / pc logic / decode side
    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        output stall,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  done,
        input  fault,
        input  fault_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller with fetch FIFO, redirect flush, end and fault detection
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          IMEM_SIZE = 18,
    parameter int          DEPTH     = 2
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    localparam int          PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [2:0]  CNT_DEPTH = 3'(DEPTH);
    localparam logic [31:0] LAST_WORD = 32'(IMEM_SIZE - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_END   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic        fault_q, fault_n;
    logic [31:0] fault_pc_q, fault_pc_n;
    logic        done_q, done_n;

    logic [31:0] entry_instr [DEPTH];
    logic [31:0] entry_pc    [DEPTH];
    logic [PW-1:0] rd_ptr, rd_n;
    logic [PW-1:0] wr_ptr, wr_n;
    logic [2:0]    count, count_n;
    logic [2:0]    remaining;

    logic        out_valid_q;
    logic [31:0] out_instr_q, out_pc_q;
    logic [31:0] head_instr_n, head_pc_n;

    logic        pop;
    logic        push;
    logic        flush;
    logic        word_ok;
    logic        space;
    logic        misaligned;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign pop        = out_valid_q & bus.out_ready;
    assign word_ok    = ((fetch_pc >> 2) <= LAST_WORD) && (bus.imem_data != 32'h0);
    assign space      = (count < CNT_DEPTH) || pop;
    assign misaligned = (bus.redirect_pc[1:0] != 2'b00);

    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.fault_pc  = fault_pc_q;

    // fetch state machine: redirect > stall > fetch, decides push/flush and next pc
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        fault_n    = fault_q;
        fault_pc_n = fault_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            S_FETCH: begin
                if (bus.redirect_valid && misaligned) begin
                    flush      = 1'b1;
                    fault_n    = 1'b1;
                    fault_pc_n = bus.redirect_pc;
                    state_n    = S_FAULT;
                end else if (bus.redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_n = bus.redirect_pc;
                end else if (bus.stall) begin
                    fetch_pc_n = fetch_pc;
                end else if (space) begin
                    if (word_ok) begin
                        push       = 1'b1;
                        fetch_pc_n = fetch_pc + 32'd4;
                    end else begin
                        state_n = S_END;
                    end
                end
            end
            S_END: begin
                if (bus.redirect_valid && misaligned) begin
                    flush      = 1'b1;
                    fault_n    = 1'b1;
                    fault_pc_n = bus.redirect_pc;
                    state_n    = S_FAULT;
                end else if (bus.redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_n = bus.redirect_pc;
                    state_n    = S_FETCH;
                end
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    // fifo bookkeeping and the head entry that the output registers will show next
    always_comb begin
        rd_n         = rd_ptr;
        wr_n         = wr_ptr;
        count_n      = count;
        remaining    = count - {2'b00, pop};
        head_instr_n = out_instr_q;
        head_pc_n    = out_pc_q;
        if (flush) begin
            rd_n    = '0;
            wr_n    = '0;
            count_n = 3'd0;
        end else begin
            if (pop) begin
                rd_n = ptr_inc(rd_ptr);
            end
            if (push) begin
                wr_n = ptr_inc(wr_ptr);
            end
            count_n = remaining + {2'b00, push};
            if (remaining == 3'd0) begin
                head_instr_n = bus.imem_data;
                head_pc_n    = fetch_pc;
            end else begin
                head_instr_n = entry_instr[rd_n];
                head_pc_n    = entry_pc[rd_n];
            end
        end
        done_n = (state_n == S_END) && (count_n == 3'd0);
    end

    // control state, pointers and sticky fault
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            fetch_pc   <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
            done_q     <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= 3'd0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            fault_q    <= fault_n;
            fault_pc_q <= fault_pc_n;
            done_q     <= done_n;
            rd_ptr     <= rd_n;
            wr_ptr     <= wr_n;
            count      <= count_n;
        end
    end

    // fifo storage: written at the tail on push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_instr[i] <= 32'h0;
                entry_pc[i]    <= 32'h0;
            end
        end else if (push) begin
            entry_instr[wr_ptr] <= bus.imem_data;
            entry_pc[wr_ptr]    <= fetch_pc;
        end
    end

    // registered head outputs; data holds its last value while the fifo is empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_pc_q    <= 32'h0;
        end else begin
            out_valid_q <= (count_n != 3'd0);
            if (count_n != 3'd0) begin
                out_instr_q <= head_instr_n;
                out_pc_q    <= head_pc_n;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    logic [31:0] mem [0:63];

    fetch_sequencer_if bus ();
    fetch_sequencer_if bus3 ();

    fetch_sequencer #(.RESET_PC(32'h0), .IMEM_SIZE(18), .DEPTH(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    fetch_sequencer #(.RESET_PC(32'h0), .IMEM_SIZE(3), .DEPTH(2)) dut3 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus3)
    );

    assign bus.imem_data  = (bus.imem_addr[31:8] == 24'd0) ? mem[bus.imem_addr[7:2]] : 32'hFFFF_FFFF;
    assign bus3.imem_data = 32'hA000_0000 | bus3.imem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h1000_0000 + i;
        end
        mem[0] = 32'h0001_1020;
        mem[1] = 32'h0064_2820;
        mem[2] = 32'hAE01_0000;
        mem[3] = 32'h0000_0000;

        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.stall          = 1'b0;
        bus.out_ready      = 1'b0;
        bus3.redirect_valid = 1'b0;
        bus3.redirect_pc    = 32'h0;
        bus3.stall          = 1'b0;
        bus3.out_ready      = 1'b1;

        repeat (2) step();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_done", bus.done, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_fault_pc", bus.fault_pc, 0);
        check("rst_imem_addr", bus.imem_addr, 0);

        // sequential fetch into end of program (word 3 is zero)
        bus.out_ready = 1'b1;
        reset = 1'b1;
        step();
        check("seq0_valid", bus.out_valid, 1);
        check("seq0_pc", bus.out_pc, 32'h0);
        check("seq0_instr", bus.out_instr, 32'h0001_1020);
        step();
        check("seq1_pc", bus.out_pc, 32'h4);
        check("seq1_instr", bus.out_instr, 32'h0064_2820);
        step();
        check("seq2_pc", bus.out_pc, 32'h8);
        check("seq2_instr", bus.out_instr, 32'hAE01_0000);
        check("seq2_done", bus.done, 0);
        step();
        check("end_done", bus.done, 1);
        check("end_valid", bus.out_valid, 0);
        check("end_addr", bus.imem_addr, 32'hC);
        check("end_pc_hold", bus.out_pc, 32'h8);
        check("size3_done", bus3.done, 1);
        check("size3_addr", bus3.imem_addr, 32'hC);

        // aligned redirect out of END
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h4;
        step();
        bus.redirect_valid = 1'b0;
        check("resume_done", bus.done, 0);
        check("resume_addr", bus.imem_addr, 32'h4);
        check("resume_valid", bus.out_valid, 0);
        step();
        check("resume_pc", bus.out_pc, 32'h4);
        step();
        check("resume_pc2", bus.out_pc, 32'h8);
        step();
        check("resume_end_done", bus.done, 1);

        // backpressure: fill to DEPTH and hold
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        repeat (5) step();
        check("bp_valid", bus.out_valid, 1);
        check("bp_pc", bus.out_pc, 32'h0);
        check("bp_addr", bus.imem_addr, 32'h8);
        bus.out_ready = 1'b1;
        step();
        check("bp_rel_pc4", bus.out_pc, 32'h4);
        step();
        check("bp_rel_pc8", bus.out_pc, 32'h8);
        step();
        check("bp_rel_done", bus.done, 1);
        check("bp_rel_valid", bus.out_valid, 0);

        // redirect with a full fifo and a pop in the same cycle
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        step();
        step();
        check("rd_full_pc", bus.out_pc, 32'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h20;
        bus.out_ready      = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        check("rd_flush_valid", bus.out_valid, 0);
        check("rd_addr", bus.imem_addr, 32'h20);
        step();
        check("rd_tgt_valid", bus.out_valid, 1);
        check("rd_tgt_pc", bus.out_pc, 32'h20);
        check("rd_tgt_instr", bus.out_instr, 32'h1000_0008);
        step();
        check("rd_next_pc", bus.out_pc, 32'h24);

        // stall: fetch frozen, fifo drains
        bus.out_ready = 1'b0;
        step();
        bus.stall     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("stall_pc1", bus.out_pc, 32'h28);
        check("stall_addr1", bus.imem_addr, 32'h2C);
        step();
        check("stall_valid", bus.out_valid, 0);
        check("stall_addr2", bus.imem_addr, 32'h2C);
        check("stall_pc_hold", bus.out_pc, 32'h28);
        bus.stall = 1'b0;
        step();
        check("unstall_pc", bus.out_pc, 32'h2C);

        // misaligned redirect -> sticky fault
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h22;
        step();
        check("flt_fault", bus.fault, 1);
        check("flt_fault_pc", bus.fault_pc, 32'h22);
        check("flt_valid", bus.out_valid, 0);
        bus.redirect_pc = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        check("flt_ign_fault", bus.fault, 1);
        check("flt_ign_fault_pc", bus.fault_pc, 32'h22);
        check("flt_ign_addr", bus.imem_addr, 32'h30);
        check("flt_ign_valid", bus.out_valid, 0);
        check("flt_done", bus.done, 0);

        // asynchronous reset clears fault; restart at RESET_PC
        #2;
        reset = 1'b0;
        #1;
        check("arst_fault", bus.fault, 0);
        check("arst_fault_pc", bus.fault_pc, 0);
        check("arst_addr", bus.imem_addr, 0);
        step();
        reset = 1'b1;
        step();
        check("restart_valid", bus.out_valid, 1);
        check("restart_pc", bus.out_pc, 32'h0);
        check("restart_instr", bus.out_instr, 32'h0001_1020);

        // reset in the middle of a pushing cycle
        #2;
        reset = 1'b0;
        #1;
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_instr", bus.out_instr, 0);
        check("midrst_pc", bus.out_pc, 0);
        check("midrst_addr", bus.imem_addr, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
